multicycle_ctrl: RTL



---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/instr_legal.sv | 22 ++
 rtl/multicycle_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode and mux-select encodings for the multicycle controller
package ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BEQ       = 4'd9,
        JAL       = 4'd10,
        TRAP      = 4'd11
    } state_e;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [1:0] ALU_ADDR   = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_ARITH  = 2'b10;
    localparam logic [1:0] ALU_JAL    = 2'b11;
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields, memory handshake and datapath controls
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       alu_funct7;
    logic [1:0] result_src;
    logic       retire;
    logic       illegal;
    logic       mem_timeout;
    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write,
               alu_src_a, alu_src_b, alu_op, alu_funct7, result_src, retire, illegal, mem_timeout
    );
    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write,
               alu_src_a, alu_src_b, alu_op, alu_funct7, result_src, retire, illegal, mem_timeout
    );
endinterface

// File: rtl/instr_legal.sv
// instr_legal: flags encodings the core implements; shared with the decode-stage checker
module instr_legal
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       legal
);
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE:          legal = {funct7_5, funct3} inside {4'b0000, 4'b1000, 4'b0111, 4'b0110,
                                                                   4'b0100, 4'b0001, 4'b0101};
            OP_ITYPE:          legal = !(funct3 inside {3'b010, 3'b011}) && !(funct3[1:0] == 2'b01 && funct7_5);
            OP_BRANCH:         legal = funct3 == 3'b000;
            OP_LOAD, OP_STORE: legal = funct3 == 3'b010;
            OP_JAL:            legal = 1'b1;
            default:           legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_ctrl_if.master   bus
);
    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);
    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;
    logic       legal, waiting;
    logic       req, wr, irw, pcw, rw, ret;
    instr_legal u_legal (
        .opcode   (bus.opcode),
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .legal    (legal)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = MEM_ADR;
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_ITYPE:          state_d = EXEC_I;
                    OP_BRANCH:         state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = TRAP;
                endcase
                if (!legal) state_d = TRAP;
            end
            MEM_ADR:   state_d = bus.opcode[5] ? MEM_WRITE : MEM_READ;
            MEM_READ:  state_d = bus.mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_d = bus.mem_ready ? FETCH : MEM_WRITE;
            EXEC_R, EXEC_I:            state_d = ALU_WB;
            MEM_WB, ALU_WB, BEQ, JAL:  state_d = FETCH;
            default:   state_d = TRAP;
        endcase
    end
    // the counter only runs while a memory access is stalled, so any state change clears it
    assign waiting   = (state_q inside {FETCH, MEM_READ, MEM_WRITE}) && !bus.mem_ready;
    assign wait_d    = !waiting ? 4'd0 : (wait_q == 4'hF ? wait_q : wait_q + 4'd1);
    assign timeout_d = timeout_q || (WAIT_MAX != 4'd0 && waiting && wait_d == WAIT_MAX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            wait_q    <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end
    always_comb begin
        req = 1'b0;
        wr  = 1'b0;
        irw = 1'b0;
        pcw = 1'b0;
        rw  = 1'b0;
        ret = 1'b0;
        bus.adr_src    = 1'b0;
        bus.pc_src     = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_RS2;
        bus.alu_op     = ALU_ADDR;
        bus.alu_funct7 = 1'b0;
        bus.result_src = RES_ALUOUT;
        case (state_q)
            FETCH: begin
                req = 1'b1;
                irw = bus.mem_ready;
                pcw = bus.mem_ready;
            end
            MEM_ADR:   bus.alu_src_b = SRCB_IMM;
            MEM_READ: begin
                req = 1'b1;
                bus.adr_src = 1'b1;
            end
            MEM_WB: begin
                rw  = 1'b1;
                ret = 1'b1;
                bus.result_src = RES_MDR;
            end
            MEM_WRITE: begin
                req = 1'b1;
                wr  = 1'b1;
                ret = bus.mem_ready;
                bus.adr_src = 1'b1;
            end
            EXEC_R: begin
                bus.alu_op     = ALU_ARITH;
                bus.alu_funct7 = bus.funct7_5;
            end
            EXEC_I: begin
                bus.alu_op    = ALU_ARITH;
                bus.alu_src_b = SRCB_IMM;
            end
            ALU_WB: begin
                rw  = 1'b1;
                ret = 1'b1;
            end
            BEQ: begin
                pcw = bus.zero;
                ret = 1'b1;
                bus.alu_op = ALU_BRANCH;
                bus.pc_src = 1'b1;
            end
            JAL: begin
                pcw = 1'b1;
                rw  = 1'b1;
                ret = 1'b1;
                bus.alu_op     = ALU_JAL;
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                bus.pc_src     = 1'b1;
            end
            default: ;
        endcase
    end
    // enables are masked by reset directly so nothing fires while rst_n is low
    assign bus.mem_req     = req & rst_n;
    assign bus.mem_write   = wr & rst_n;
    assign bus.ir_write    = irw & rst_n;
    assign bus.pc_write    = pcw & rst_n;
    assign bus.reg_write   = rw & rst_n;
    assign bus.retire      = ret & rst_n;
    assign bus.illegal     = state_q == TRAP;
    assign bus.mem_timeout = timeout_q;
endmodule
